instruction_fetch_sequencer: RTL and testbench
==============================================

// Module: instruction_fetch_sequencer
// PURPOSE
//  Sequences the 32-bit instruction memory for the LEGv8 core: owns the PC, drives the
//  word address, tracks the 1-cycle synchronous read and hands instructions to decode
//  over a valid/ready handshake. Absorbs decode stalls in a 2-entry skid buffer and
//  handles taken-branch redirects and HALT. Sits between Instruction_Memory_Thirty_Two_Bit and decode.
// PARAMETERS
//  ADDR_W      32            PC / byte-address width
//  RESET_PC    32'h0         PC loaded on reset
//  HALT_INSTR  32'hD4400000  encoding that stops fetch once delivered
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       synchronous, active-high
//  start          in   1       IDLE->RUN pulse
//  imem_addr      out  ADDR_W  word address to instruction memory (= pc>>2)
//  imem_instr     in   32      memory read data, valid 1 cycle after imem_addr
//  if_valid       out  1       if_instr/if_pc hold a valid instruction
//  if_ready       in   1       decode accepts when if_valid & if_ready
//  if_instr       out  32      instruction to decode
//  if_pc          out  ADDR_W  byte PC of if_instr
//  redirect       in   1       taken branch/jump; wins over all other events
//  redirect_pc    in   ADDR_W  byte target, bits[1:0] ignored (forced 0)
//  halted         out  1       high in HALTED state
// BEHAVIOUR
//  - Reset: state=IDLE, pc=RESET_PC, imem_addr=RESET_PC>>2, if_valid=0, if_instr=0,
//    if_pc=0, halted=0, buffer empty, inflight=0. Reset mid-operation discards everything.
//  - FSM: IDLE --start--> RUN; RUN --HALT_INSTR accepted by decode--> HALTED;
//    HALTED exits only via reset. redirect in IDLE/HALTED is ignored.
//  - Issue (RUN only): fetch issued at cycle N when count+inflight<2 and no redirect;
//    imem_addr=pc>>2 that cycle, pc<=pc+4, inflight<=1 with tag pc. At N+1 imem_instr
//    is pushed into the buffer with its tag. Peak rate 1 instr/cycle, first if_valid 2
//    cycles after start.
//  - Buffer: 2-entry FIFO, head drives if_valid/if_instr/if_pc. Push and pop in the same
//    cycle allowed at any count. Overflow impossible by issue rule; assertion required.
//  - Stall: if_ready=0 with if_valid=1 -> if_instr/if_pc held stable, no pop; fetch stops
//    once count+inflight=2; resumes the cycle after a pop. No instruction lost or duplicated.
//  - Redirect (RUN): that cycle buffer cleared, inflight result dropped, no issue;
//    pc<=redirect_pc&~3. Next cycle fetch of target issued; target valid 2 cycles after
//    redirect. A handshake in the redirect cycle still completes (decode owns the branch).
//  - HALT: after HALT_INSTR is accepted, no pop/push; buffer and inflight flushed,
//    if_valid=0, halted=1 next cycle. HALT_INSTR is delivered normally, exactly once.
//  - pc wraps modulo 2^ADDR_W; no exception. imem_addr only changes on issue/redirect.
// STRUCTURE
//  - Shared package legv8_pkg: HALT_INSTR constant, fetch state enum
//    {FS_IDLE,FS_RUN,FS_HALTED}, INSTR_W=32.
//  - One sub-module: fetch_skid_buffer (2-entry {instr,pc} FIFO, push/pop/flush,
//    count). FSM, pc, inflight tracking stay in this module.
// TESTING (memory model: word k holds 10-k, HALT_INSTR at word 20)
//  - Reset, start, if_ready=1 -> if_valid 2 cycles after start, then if_instr 10,9,8,...
//    one per cycle with if_pc 0,4,8,...
//  - Hold if_ready=0 for 5 cycles after first valid -> if_instr stays 10, imem_addr
//    stops at word 2; release -> 9,8,7 delivered, no gaps or repeats.
//  - redirect with redirect_pc=0x1F (-> 0x1C) while buffer full -> buffered words dropped,
//    2 cycles later if_instr=3, if_pc=0x1C.
//  - Run to word 20 -> HALT_INSTR delivered once, halted=1 next cycle, if_valid=0,
//    redirect then ignored, imem_addr frozen.
//  - Assert reset mid-stall with buffer full -> next cycle all outputs at reset values;
//    start again -> sequence restarts at if_instr=10.
//  - RESET_PC=32'hFFFFFFFC -> first instr from word 0x3FFFFFFF, next if_pc=0 (wrap).

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end definitions: instruction width, HALT encoding and fetch states.
package legv8_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] HALT_INSTR = 32'hD440_0000;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_RUN    = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry {instr, pc} FIFO between instruction memory and decode.
// Head entry drives the decode-side outputs; flush empties it in one cycle.
module fetch_skid_buffer
    import legv8_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [ADDR_W-1:0]  push_pc,
    output logic               head_valid,
    output logic [INSTR_W-1:0] head_instr,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [1:0]         count
);

    logic [INSTR_W-1:0] instr_r [2];
    logic [ADDR_W-1:0]  pc_r    [2];
    logic               wr_ptr_r;
    logic               rd_ptr_r;
    logic [1:0]         count_r;

    // Storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                instr_r[i] <= {INSTR_W{1'b0}};
                pc_r[i]    <= {ADDR_W{1'b0}};
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                instr_r[wr_ptr_r] <= push_instr;
                pc_r[wr_ptr_r]    <= push_pc;
                wr_ptr_r          <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_valid = (count_r != 2'd0);
    assign head_instr = instr_r[rd_ptr_r];
    assign head_pc    = pc_r[rd_ptr_r];
    assign count      = count_r;

endmodule

// File: rtl/fetch_skid_buffer_checker.sv
// Occupancy checks for the fetch skid buffer: never overflows, never pops when empty.
module fetch_skid_buffer_checker (
    input logic       clk,
    input logic       reset,
    input logic       push,
    input logic       pop,
    input logic       flush,
    input logic [1:0] count
);

    // Sample buffer controls every cycle outside reset and flush.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            assert (!(push && !pop && (count == 2'd2)));
            assert (!(pop && (count == 2'd0)));
        end
    end

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// LEGv8 fetch front end: owns the PC, issues synchronous instruction-memory reads and
// delivers instructions to decode through a 2-entry skid buffer with redirect and HALT.
module instruction_fetch_sequencer
    import legv8_pkg::*;
#(
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC   = {ADDR_W{1'b0}},
    parameter logic [INSTR_W-1:0] HALT_INSTR = legv8_pkg::HALT_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
);

    fetch_state_e       state_r;
    fetch_state_e       state_s;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  tag_r;
    logic               inflight_r;

    logic               buf_valid_s;
    logic [INSTR_W-1:0] buf_instr_s;
    logic [ADDR_W-1:0]  buf_pc_s;
    logic [1:0]         buf_count_s;

    logic               run_s;
    logic               handshake_s;
    logic               redirect_s;
    logic               halt_accept_s;
    logic               flush_s;
    logic               pop_s;
    logic               push_s;
    logic               issue_s;

    // Event decode; an entry popped this cycle frees a slot for this cycle's issue,
    // which keeps the pipe at one instruction per cycle without overflowing.
    always_comb begin
        run_s         = (state_r == FS_RUN);
        handshake_s   = buf_valid_s & if_ready;
        redirect_s    = run_s & redirect;
        halt_accept_s = run_s & ~redirect & handshake_s & (buf_instr_s == HALT_INSTR);
        flush_s       = redirect_s | halt_accept_s;
        pop_s         = run_s & handshake_s & ~flush_s;
        push_s        = run_s & inflight_r & ~flush_s;
        issue_s       = run_s & ~flush_s &
                        (({1'b0, buf_count_s} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s}));
    end

    // Fetch state next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            FS_IDLE: begin
                if (start) begin
                    state_s = FS_RUN;
                end else begin
                    state_s = FS_IDLE;
                end
            end
            FS_RUN: begin
                if (halt_accept_s) begin
                    state_s = FS_HALTED;
                end else begin
                    state_s = FS_RUN;
                end
            end
            FS_HALTED: state_s = FS_HALTED;
            default:   state_s = FS_IDLE;
        endcase
    end

    // State, PC and in-flight read tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= FS_IDLE;
            pc_r       <= RESET_PC;
            tag_r      <= {ADDR_W{1'b0}};
            inflight_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (redirect_s) begin
                pc_r <= {redirect_pc[ADDR_W-1:2], 2'b00};
            end else if (issue_s) begin
                pc_r <= pc_r + {{(ADDR_W-3){1'b0}}, 3'd4};
            end
            inflight_r <= issue_s;
            if (issue_s) begin
                tag_r <= pc_r;
            end
        end
    end

    fetch_skid_buffer #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (flush_s),
        .push_instr (imem_instr),
        .push_pc    (tag_r),
        .head_valid (buf_valid_s),
        .head_instr (buf_instr_s),
        .head_pc    (buf_pc_s),
        .count      (buf_count_s)
    );

    fetch_skid_buffer_checker u_skid_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .count (buf_count_s)
    );

    // pc only moves on issue or redirect, so the word address does too.
    assign imem_addr = {2'b00, pc_r[ADDR_W-1:2]};
    assign if_valid  = buf_valid_s;
    assign if_instr  = buf_instr_s;
    assign if_pc     = buf_pc_s;
    assign halted    = (state_r == FS_HALTED);

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Self-checking bench for instruction_fetch_sequencer: vector table for the start-up
// sequence, scoreboard of delivered instructions, directed stall/redirect/halt/reset/wrap cases.
module tb_instruction_fetch_sequencer;

    localparam logic [31:0] HALT_W = 32'hD440_0000;

    logic        clk = 1'b0;
    logic        reset, start, if_ready, redirect;
    logic [31:0] redirect_pc;

    logic [31:0] imem_addr, imem_instr, if_instr, if_pc;
    logic        if_valid, halted;
    logic [31:0] w_imem_addr, w_imem_instr, w_if_instr, w_if_pc;
    logic        w_if_valid, w_halted;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    instruction_fetch_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr),
        .imem_instr(imem_instr), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .redirect(redirect),
        .redirect_pc(redirect_pc), .halted(halted)
    );

    instruction_fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .start(start), .imem_addr(w_imem_addr),
        .imem_instr(w_imem_instr), .if_valid(w_if_valid), .if_ready(if_ready),
        .if_instr(w_if_instr), .if_pc(w_if_pc), .redirect(redirect),
        .redirect_pc(redirect_pc), .halted(w_halted)
    );

    // Memory model: word k holds 10-k, HALT at word 20.
    function automatic logic [31:0] mem_word(input logic [31:0] waddr);
        if (waddr == 32'd20) return HALT_W;
        return 32'd10 - waddr;
    endfunction

    always_ff @(posedge clk) begin
        imem_instr   <= mem_word(imem_addr);
        w_imem_instr <= mem_word(w_imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_words(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            exp_q.push_back('{instr: mem_word(32'(k)), pc: 32'(k) * 32'd4});
        end
    endtask

    // Compare any handshake due at the coming edge, then advance one clock.
    task automatic cycle();
        exp_t e;
        if (if_valid && if_ready && !reset) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got instr %h pc %h expected none", if_instr, if_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr", if_instr, e.instr);
                chk("sb_pc", if_pc, e.pc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; if_ready = 1'b0;
        exp_q.delete();
        cycle();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        while (!if_valid && n < bound) begin
            cycle();
            n++;
        end
        chk("wait_valid", {31'd0, if_valid}, 32'd1);
    endtask

    task automatic start_stalled();
        start = 1'b1; if_ready = 1'b0;
        cycle();
        start = 1'b0;
        wait_valid(8);
    endtask

    initial begin
        logic [31:0] frozen;
        logic        hs_halt;
        int          halt_cnt;

        vecs[0] = '{1'b1, 1'b0, 32'd0,  32'd0,  32'd0};
        vecs[1] = '{1'b1, 1'b0, 32'd0,  32'd0,  32'd1};
        vecs[2] = '{1'b1, 1'b1, 32'd10, 32'd0,  32'd2};
        vecs[3] = '{1'b1, 1'b1, 32'd9,  32'd4,  32'd3};
        vecs[4] = '{1'b1, 1'b1, 32'd8,  32'd8,  32'd4};
        vecs[5] = '{1'b1, 1'b1, 32'd7,  32'd12, 32'd5};

        // Reset values
        do_reset();
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        // Start-up sequence, one row per cycle after the start edge
        push_words(0, 3);
        start = 1'b1; if_ready = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if_ready = vecs[i].rdy;
            chk($sformatf("vec%0d_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_instr", i), if_instr, vecs[i].exp_instr);
                chk($sformatf("vec%0d_pc", i), if_pc, vecs[i].exp_pc);
            end
            cycle();
        end
        if_ready = 1'b0;
        chk("startup_drained", 32'(exp_q.size()), 32'd0);

        // Decode stall for 5 cycles, then release
        do_reset();
        push_words(0, 5);
        start_stalled();
        for (int i = 0; i < 5; i++) begin
            chk("stall_instr", if_instr, 32'd10);
            chk("stall_pc", if_pc, 32'd0);
            cycle();
        end
        chk("stall_addr", imem_addr, 32'd2);
        if_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("release_no_gap", {31'd0, if_valid}, 32'd1);
            cycle();
        end
        if_ready = 1'b0;
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // Redirect while the buffer is full; handshake in the redirect cycle completes
        do_reset();
        exp_q.push_back('{instr: 32'd10, pc: 32'd0});
        push_words(7, 9);
        start_stalled();
        cycle();
        redirect = 1'b1; redirect_pc = 32'h0000_001F; if_ready = 1'b1;
        cycle();
        redirect = 1'b0; if_ready = 1'b0;
        chk("redir_valid0", {31'd0, if_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'd7);
        cycle();
        chk("redir_valid1", {31'd0, if_valid}, 32'd0);
        cycle();
        chk("redir_valid2", {31'd0, if_valid}, 32'd1);
        chk("redir_instr", if_instr, 32'd3);
        chk("redir_pc", if_pc, 32'h0000_001C);
        if_ready = 1'b1;
        repeat (3) cycle();
        if_ready = 1'b0;
        chk("redir_drained", 32'(exp_q.size()), 32'd0);

        // Run to HALT at word 20
        do_reset();
        push_words(0, 20);
        start = 1'b1; if_ready = 1'b1;
        cycle();
        start = 1'b0;
        halt_cnt = 0;
        for (int i = 0; i < 60 && !halted; i++) begin
            hs_halt = if_valid && if_ready && (if_instr == HALT_W);
            cycle();
            if (hs_halt) begin
                halt_cnt++;
                chk("halt_next_cycle", {31'd0, halted}, 32'd1);
                chk("halt_valid", {31'd0, if_valid}, 32'd0);
            end
        end
        chk("halt_reached", {31'd0, halted}, 32'd1);
        chk("halt_once", 32'(halt_cnt), 32'd1);
        chk("halt_drained", 32'(exp_q.size()), 32'd0);
        frozen = imem_addr;
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        cycle();
        redirect = 1'b0;
        repeat (3) cycle();
        chk("halt_addr_frozen", imem_addr, frozen);
        chk("halt_stays", {31'd0, halted}, 32'd1);
        chk("halt_no_valid", {31'd0, if_valid}, 32'd0);
        if_ready = 1'b0;

        // Reset mid-stall with the buffer full, then restart
        do_reset();
        start_stalled();
        cycle();
        chk("full_valid", {31'd0, if_valid}, 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("midrst_valid", {31'd0, if_valid}, 32'd0);
        chk("midrst_instr", if_instr, 32'd0);
        chk("midrst_pc", if_pc, 32'd0);
        chk("midrst_addr", imem_addr, 32'd0);
        chk("midrst_halted", {31'd0, halted}, 32'd0);
        push_words(0, 2);
        start = 1'b1; if_ready = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        chk("restart_valid", {31'd0, if_valid}, 32'd1);
        chk("restart_instr", if_instr, 32'd10);
        repeat (3) cycle();
        if_ready = 1'b0;
        chk("restart_drained", 32'(exp_q.size()), 32'd0);

        // PC wrap on the RESET_PC=0xFFFFFFFC instance
        do_reset();
        chk("wrap_rst_addr", w_imem_addr, 32'h3FFF_FFFF);
        push_words(0, 1);
        start = 1'b1; if_ready = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        chk("wrap_valid", {31'd0, w_if_valid}, 32'd1);
        chk("wrap_instr0", w_if_instr, mem_word(32'h3FFF_FFFF));
        chk("wrap_pc0", w_if_pc, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_instr1", w_if_instr, 32'd10);
        chk("wrap_pc1", w_if_pc, 32'd0);
        cycle();
        if_ready = 1'b0;
        chk("wrap_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
